// File: rtl/sha256_msg_padder_if.sv
// Bundle of the message-word input channel and the padded-block output channel
// of the SHA-256 message padder, plus a read-only view of the padder's FSM state.
interface sha256_msg_padder_if;
    // Both channels use valid/ready. A transfer happens on a rising clk edge
    // where valid and ready are both 1. The sender holds valid and its payload
    // stable until that transfer. The receiver may raise or lower ready freely.
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_last;
    logic [2:0]   in_nbytes;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         blk_first;
    logic         blk_final;
    logic [1:0]   dbg_state;

    // Message source / block consumer side.
    modport master (
        output in_valid, in_data, in_last, in_nbytes, blk_ready,
        input  in_ready, blk_valid, blk_data, blk_first, blk_final, dbg_state
    );

    // Padder side.
    modport slave (
        input  in_valid, in_data, in_last, in_nbytes, blk_ready,
        output in_ready, blk_valid, blk_data, blk_first, blk_final, dbg_state
    );
endinterface

// File: rtl/sha256_msg_padder.sv
// Collects a 32-bit big-endian word stream, appends 0x80, zero fill and the
// 64-bit bit length, and hands out complete 512-bit blocks tagged first/final.
module sha256_msg_padder #(
    parameter int LEN_CNT_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      zeroize,
    sha256_msg_padder_if.slave        bus,
    output logic                      busy,
    output logic                      err
);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        PAD  = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t                   state, state_d;
    logic [31:0]              buf_q [16];
    logic [31:0]              buf_d [16];
    logic [3:0]               widx, widx_d;
    logic [LEN_CNT_WIDTH-1:0] nbyte, nbyte_d;
    logic                     first_f, first_d;
    logic                     pad80_pend, pad80_d;
    logic                     len_pend, len_d;
    logic                     final_f, final_d;
    logic                     err_q, err_d;

    logic [2:0]               n_add;
    logic [31:0]              fill_word;
    logic [LEN_CNT_WIDTH:0]   nbyte_sum;
    logic [63:0]              bit_len;

    // Byte count of the word being accepted; oversized in_nbytes saturates at 4.
    always_comb begin
        n_add = 3'd4;
        if (bus.in_last && (bus.in_nbytes < 3'd4)) begin
            n_add = bus.in_nbytes;
        end
    end

    // On a short last word the 0x80 marker lands right after the last valid byte.
    always_comb begin
        fill_word = bus.in_data;
        if (bus.in_last) begin
            case (n_add)
                3'd0:    fill_word = 32'h8000_0000;
                3'd1:    fill_word = {bus.in_data[31:24], 24'h80_0000};
                3'd2:    fill_word = {bus.in_data[31:16], 16'h8000};
                3'd3:    fill_word = {bus.in_data[31:8], 8'h80};
                default: fill_word = bus.in_data;
            endcase
        end
    end

    assign nbyte_sum = {1'b0, nbyte} + (LEN_CNT_WIDTH + 1)'(n_add);
    assign bit_len   = 64'(nbyte) << 3;

    always_comb begin
        state_d = state;
        buf_d   = buf_q;
        widx_d  = widx;
        nbyte_d = nbyte;
        first_d = first_f;
        pad80_d = pad80_pend;
        len_d   = len_pend;
        final_d = final_f;
        err_d   = err_q;

        case (state)
            FILL: begin
                if (bus.in_valid) begin
                    buf_d[widx] = fill_word;
                    nbyte_d     = nbyte_sum[LEN_CNT_WIDTH-1:0];
                    if (nbyte_sum[LEN_CNT_WIDTH]) begin
                        err_d = 1'b1;
                    end
                    if (!bus.in_last) begin
                        if (widx == 4'd15) begin
                            widx_d  = 4'd0;
                            final_d = 1'b0;
                            state_d = EMIT;
                        end else begin
                            widx_d = widx + 4'd1;
                        end
                    end else begin
                        if (n_add == 3'd4) begin
                            pad80_d = 1'b1;
                        end
                        if (widx == 4'd15) begin
                            len_d   = 1'b1;
                            final_d = 1'b0;
                            state_d = EMIT;
                        end else begin
                            widx_d  = widx + 4'd1;
                            state_d = PAD;
                        end
                    end
                end
            end

            PAD: begin
                if ((widx == 4'd14) && !pad80_pend) begin
                    buf_d[14] = bit_len[63:32];
                    buf_d[15] = bit_len[31:0];
                    final_d   = 1'b1;
                    state_d   = EMIT;
                end else begin
                    buf_d[widx] = pad80_pend ? 32'h8000_0000 : 32'h0;
                    pad80_d     = 1'b0;
                    if (widx == 4'd15) begin
                        // No room left for the length: it goes in a follow-up block.
                        len_d   = 1'b1;
                        final_d = 1'b0;
                        state_d = EMIT;
                    end else begin
                        widx_d = widx + 4'd1;
                    end
                end
            end

            EMIT: begin
                if (bus.blk_ready) begin
                    first_d = 1'b0;
                    widx_d  = 4'd0;
                    if (final_f) begin
                        nbyte_d = '0;
                        first_d = 1'b1;
                        state_d = FILL;
                    end else if (len_pend || pad80_pend) begin
                        for (int i = 0; i < 16; i++) begin
                            buf_d[i] = 32'h0;
                        end
                        len_d   = 1'b0;
                        state_d = PAD;
                    end else begin
                        state_d = FILL;
                    end
                end
            end

            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FILL;
            widx       <= 4'd0;
            nbyte      <= '0;
            first_f    <= 1'b1;
            pad80_pend <= 1'b0;
            len_pend   <= 1'b0;
            final_f    <= 1'b0;
            err_q      <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                buf_q[i] <= 32'h0;
            end
        end else if (zeroize) begin
            state      <= FILL;
            widx       <= 4'd0;
            nbyte      <= '0;
            first_f    <= 1'b1;
            pad80_pend <= 1'b0;
            len_pend   <= 1'b0;
            final_f    <= 1'b0;
            err_q      <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                buf_q[i] <= 32'h0;
            end
        end else begin
            state      <= state_d;
            widx       <= widx_d;
            nbyte      <= nbyte_d;
            first_f    <= first_d;
            pad80_pend <= pad80_d;
            len_pend   <= len_d;
            final_f    <= final_d;
            err_q      <= err_d;
            for (int i = 0; i < 16; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

    // Every output below is a register or a decode of the state register only.
    assign bus.in_ready  = (state == FILL);
    assign bus.blk_valid = (state == EMIT);
    assign bus.blk_first = first_f;
    assign bus.blk_final = final_f;
    assign bus.dbg_state = state;
    assign busy          = (state != FILL) || (widx != 4'd0);
    assign err           = err_q;

    for (genvar g = 0; g < 16; g++) begin : g_pack
        assign bus.blk_data[511 - 32*g -: 32] = buf_q[g];
    end

endmodule
